apu_square_channel1: RTL and testbench

//  Game Boy APU channel 1: square wave with sweep, duty, length counter and volume envelope.

---
 rtl/apu_square_channel1_if.sv | 14 +
 rtl/apu_square_channel1.sv | 255 +++++++++++++++++++++++++
 tb/tb_apu_square_channel1.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_square_channel1_if.sv
// IO register bus control for the APU channel blocks: address, write strobe
// and read enable, both strobes active-low. The bidirectional data byte is a
// plain inout port on the channel because it is tri-stated.
//   addr : 16-bit IO register address
//   we_l : write strobe, sampled on the rising clock edge
//   re_l : read enable, data is returned combinationally
interface apu_square_channel1_if;
  logic [15:0] addr;
  logic        we_l;
  logic        re_l;

  modport master (output addr, output we_l, output re_l);
  modport slave  (input  addr, input  we_l, input  re_l);
endinterface

// File: rtl/apu_square_channel1.sv
// Game Boy APU channel 1: square wave with frequency sweep, duty select,
// length counter and volume envelope, programmed through NR10-NR14 (FF10-FF14).
// Optional feature macro: APU_CH1_SWEEP_EN enables the frequency sweep unit;
// without it NR10 is stored and readable but has no effect.
// Ports:
//   I_CLK          clock
//   I_RESET        synchronous active-high reset
//   ioreg          IO register bus control (addr, we_l, re_l)
//   IO_IOREG_DATA  IO register data, driven only during a decoded read
//   O_SAMPLE       registered 4-bit amplitude
//   O_ENABLED      channel-on status
module apu_square_channel1 #(
  parameter int unsigned TIMER_DIV = 4,
  parameter int unsigned FRAME_DIV = 8192
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  apu_square_channel1_if.slave ioreg,
  inout  wire  [7:0]           IO_IOREG_DATA,
  output logic [3:0]           O_SAMPLE,
  output logic                 O_ENABLED
);
  localparam int unsigned PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int unsigned FRM_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [6:0]       nr10_q, nr10_d;
  logic [1:0]       duty_q, duty_d;
  logic [7:0]       nr12_q, nr12_d;
  logic [10:0]      freq_q, freq_d;
  logic             len_en_q, len_en_d;
  logic [6:0]       length_q, length_d;
  logic [3:0]       vol_q, vol_d;
  logic [2:0]       env_tmr_q, env_tmr_d;
  logic [2:0]       step_q, step_d;
  logic [11:0]      ftmr_q, ftmr_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [2:0]       fs_q, fs_d;
  logic             en_q, en_d;
  logic [3:0]       sample_q, sample_d;
  logic             trig_ovf;

  // Bus decode
  logic       in_rng, wr_en, rd_hit, trig, dac_on;
  logic [2:0] sel;
  logic [7:0] wdata, rd_data, wave;
  logic       tick, frame_tick, len_clk, env_clk;

  assign in_rng     = (ioreg.addr >= 16'hFF10) && (ioreg.addr <= 16'hFF14);
  assign sel        = ioreg.addr[2:0];
  assign wdata      = IO_IOREG_DATA;
  assign wr_en      = !ioreg.we_l && in_rng;
  assign rd_hit     = !ioreg.re_l && in_rng;
  assign trig       = wr_en && (sel == 3'd4) && wdata[7];
  assign dac_on     = (nr12_q[7:3] != 5'd0);
  assign tick       = (pre_q == PRE_W'(TIMER_DIV - 1));
  assign frame_tick = (frm_q == FRM_W'(FRAME_DIV - 1));
  assign len_clk    = frame_tick && !fs_q[0];
  assign env_clk    = frame_tick && (fs_q == 3'd7);

  // Duty pattern, bit index = duty step
  always_comb begin
    case (duty_q)
      2'b00:   wave = 8'b1000_0000;
      2'b01:   wave = 8'b1000_0001;
      2'b10:   wave = 8'b1110_0001;
      default: wave = 8'b0111_1110;
    endcase
  end

`ifdef APU_CH1_SWEEP_EN
  logic [10:0] shadow_q, shadow_d;
  logic [3:0]  swp_tmr_q, swp_tmr_d;
  logic        swp_act_q, swp_act_d;
  logic [11:0] swp_new, swp_chk;
  logic        swp_clk;

  assign swp_clk = frame_tick && (fs_q[1:0] == 2'b10);

  function automatic logic [11:0] sweep_calc(input logic [10:0] f, input logic [2:0] sh,
                                             input logic neg);
    logic [11:0] d;
    d = {1'b0, f} >> sh;
    sweep_calc = neg ? ({1'b0, f} - d) : ({1'b0, f} + d);
  endfunction
`endif

  // Next-state logic; writes and triggers override frame events on the same counter
  always_comb begin
    nr10_d    = nr10_q;
    duty_d    = duty_q;
    nr12_d    = nr12_q;
    freq_d    = freq_q;
    len_en_d  = len_en_q;
    length_d  = length_q;
    vol_d     = vol_q;
    env_tmr_d = env_tmr_q;
    step_d    = step_q;
    ftmr_d    = ftmr_q;
    en_d      = en_q;
    trig_ovf  = 1'b0;
    pre_d     = tick ? '0 : pre_q + 1'b1;
    frm_d     = frame_tick ? '0 : frm_q + 1'b1;
    fs_d      = frame_tick ? fs_q + 3'd1 : fs_q;
`ifdef APU_CH1_SWEEP_EN
    shadow_d  = shadow_q;
    swp_tmr_d = swp_tmr_q;
    swp_act_d = swp_act_q;
    swp_new   = '0;
    swp_chk   = '0;
`endif

    if (wr_en && sel == 3'd0) nr10_d = wdata[6:0];
    if (wr_en && sel == 3'd2) nr12_d = wdata;
    if (wr_en && sel == 3'd3) freq_d[7:0] = wdata;
    if (wr_en && sel == 3'd4) begin
      len_en_d     = wdata[6];
      freq_d[10:8] = wdata[2:0];
    end

    // Frequency timer and duty step
    if (trig) begin
      ftmr_d = 12'd2048 - 12'(freq_d);
    end else if (tick) begin
      if (ftmr_q <= 12'd1) begin
        ftmr_d = 12'd2048 - 12'(freq_q);
        step_d = step_q + 3'd1;
      end else begin
        ftmr_d = ftmr_q - 12'd1;
      end
    end

    // Length counter
    if (wr_en && sel == 3'd1) begin
      duty_d   = wdata[7:6];
      length_d = 7'd64 - 7'(wdata[5:0]);
    end else if (trig) begin
      if (length_q == 7'd0) length_d = 7'd64;
    end else if (len_clk && len_en_q && length_q != 7'd0) begin
      length_d = length_q - 7'd1;
      if (length_q == 7'd1) en_d = 1'b0;
    end

    // Volume envelope
    if (trig) begin
      vol_d     = nr12_q[7:4];
      env_tmr_d = nr12_q[2:0];
    end else if (env_clk && nr12_q[2:0] != 3'd0) begin
      if (env_tmr_q <= 3'd1) begin
        env_tmr_d = nr12_q[2:0];
        if (nr12_q[3] && vol_q != 4'd15) vol_d = vol_q + 4'd1;
        else if (!nr12_q[3] && vol_q != 4'd0) vol_d = vol_q - 4'd1;
      end else begin
        env_tmr_d = env_tmr_q - 3'd1;
      end
    end

`ifdef APU_CH1_SWEEP_EN
    // Frequency sweep; a CPU write to the frequency registers wins over it
    if (trig) begin
      shadow_d  = freq_d;
      swp_tmr_d = (nr10_q[6:4] == 3'd0) ? 4'd8 : 4'(nr10_q[6:4]);
      swp_act_d = (nr10_q[6:4] != 3'd0) || (nr10_q[2:0] != 3'd0);
      if (nr10_q[2:0] != 3'd0) begin
        swp_chk  = sweep_calc(freq_d, nr10_q[2:0], nr10_q[3]);
        trig_ovf = (swp_chk > 12'd2047);
      end
    end else if (swp_clk && !(wr_en && (sel == 3'd3 || sel == 3'd4))) begin
      if (swp_tmr_q <= 4'd1) begin
        swp_tmr_d = (nr10_q[6:4] == 3'd0) ? 4'd8 : 4'(nr10_q[6:4]);
        if (swp_act_q && nr10_q[6:4] != 3'd0) begin
          swp_new = sweep_calc(shadow_q, nr10_q[2:0], nr10_q[3]);
          if (swp_new > 12'd2047) begin
            en_d = 1'b0;
          end else if (nr10_q[2:0] != 3'd0) begin
            shadow_d = swp_new[10:0];
            freq_d   = swp_new[10:0];
            swp_chk  = sweep_calc(swp_new[10:0], nr10_q[2:0], nr10_q[3]);
            if (swp_chk > 12'd2047) en_d = 1'b0;
          end
        end
      end else begin
        swp_tmr_d = swp_tmr_q - 4'd1;
      end
    end
`endif

    if (!dac_on) en_d = 1'b0;
    if (trig)    en_d = dac_on && !trig_ovf;

    sample_d = (en_q && wave[step_q]) ? vol_q : 4'd0;
  end

  // State registers
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      nr10_q    <= '0;
      duty_q    <= '0;
      nr12_q    <= '0;
      freq_q    <= '0;
      len_en_q  <= 1'b0;
      length_q  <= '0;
      vol_q     <= '0;
      env_tmr_q <= '0;
      step_q    <= '0;
      ftmr_q    <= '0;
      pre_q     <= '0;
      frm_q     <= '0;
      fs_q      <= '0;
      en_q      <= 1'b0;
      sample_q  <= '0;
`ifdef APU_CH1_SWEEP_EN
      shadow_q  <= '0;
      swp_tmr_q <= '0;
      swp_act_q <= 1'b0;
`endif
    end else begin
      nr10_q    <= nr10_d;
      duty_q    <= duty_d;
      nr12_q    <= nr12_d;
      freq_q    <= freq_d;
      len_en_q  <= len_en_d;
      length_q  <= length_d;
      vol_q     <= vol_d;
      env_tmr_q <= env_tmr_d;
      step_q    <= step_d;
      ftmr_q    <= ftmr_d;
      pre_q     <= pre_d;
      frm_q     <= frm_d;
      fs_q      <= fs_d;
      en_q      <= en_d;
      sample_q  <= sample_d;
`ifdef APU_CH1_SWEEP_EN
      shadow_q  <= shadow_d;
      swp_tmr_q <= swp_tmr_d;
      swp_act_q <= swp_act_d;
`endif
    end
  end

  // Read-back with unused bits forced high
  always_comb begin
    case (sel)
      3'd0:    rd_data = {1'b1, nr10_q};
      3'd1:    rd_data = {duty_q, 6'h3F};
      3'd2:    rd_data = nr12_q;
      3'd4:    rd_data = {1'b1, len_en_q, 6'h3F};
      default: rd_data = 8'hFF;
    endcase
  end

  assign IO_IOREG_DATA = rd_hit ? rd_data : 8'hzz;
  assign O_SAMPLE      = sample_q;
  assign O_ENABLED     = en_q;
endmodule

// File: tb/tb_apu_square_channel1.sv
// Directed bench for apu_square_channel1 (TIMER_DIV=1, FRAME_DIV=64).
// Frame events are predicted from a local edge counter: with the frame
// counter starting at reset, tick k lands on edge 64*(k+1), so length clocks
// fall on edges = 64 mod 128, sweep clocks on 192 mod 256, envelope on 0 mod 512.
module tb_apu_square_channel1;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_wdata = 8'h00;
  wire  [7:0] data_bus;
  logic [3:0] sample;
  logic       enabled;
  int         edges = 0;
  int         n_chk = 0;
  int         n_bad = 0;

  apu_square_channel1_if bus_if ();

  apu_square_channel1 #(.TIMER_DIV(1), .FRAME_DIV(64)) dut (
    .I_CLK        (clk),
    .I_RESET      (rst),
    .ioreg        (bus_if),
    .IO_IOREG_DATA(data_bus),
    .O_SAMPLE     (sample),
    .O_ENABLED    (enabled)
  );

  assign data_bus = tb_oe ? tb_wdata : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One-cycle write, called just after a falling edge
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr = a;
    tb_wdata    = d;
    tb_oe       = 1'b1;
    bus_if.we_l = 1'b0;
    @(negedge clk);
    bus_if.we_l = 1'b1;
    tb_oe       = 1'b0;
    bus_if.addr = 16'h0000;
  endtask

  // Combinational read; with keep set the bench drives 5A to expose a stray driver
  task automatic rd(input logic [15:0] a, input logic keep, output logic [7:0] d);
    bus_if.addr = a;
    tb_wdata    = 8'h5A;
    tb_oe       = keep;
    bus_if.re_l = 1'b0;
    #1;
    d = data_bus;
    bus_if.re_l = 1'b1;
    tb_oe       = 1'b0;
    bus_if.addr = 16'h0000;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic keep,
                        input logic [7:0] exp);
    logic [7:0] d;
    rd(a, keep, d);
    chk(tag, 16'(d), 16'(exp));
  endtask

  task automatic wait_evt(input int modv, input int rem);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (edges != 0 && (edges % modv) == rem) break;
    end
  endtask

  task automatic peak(output logic [3:0] pk);
    pk = 4'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sample > pk) pk = sample;
    end
  endtask

  initial begin
    logic       found;
    logic [3:0] prev, pk, hi_val;
    int         hi_len, lo_len;

    bus_if.addr = 16'h0000;
    bus_if.we_l = 1'b1;
    bus_if.re_l = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enabled", 16'(enabled), 16'd0);
    chk("rst_sample", 16'(sample), 16'd0);
    rd_chk("rst_nr12", 16'hFF12, 1'b0, 8'h00);
    rd_chk("rst_nr10", 16'hFF10, 1'b0, 8'h80);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: 50% duty tone at freq 0x6D6 -> 298 ticks per step
    wr(16'hFF11, 8'h80);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF13, 8'hD6);
    wr(16'hFF14, 8'h86);
    @(negedge clk);
    chk("t1_enabled", 16'(enabled), 16'd1);
    found = 1'b0;
    prev  = sample;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (prev == 4'd0 && sample != 4'd0) begin
        found = 1'b1;
        break;
      end
      prev = sample;
    end
    chk("t1_rise_seen", 16'(found), 16'd1);
    hi_val = sample;
    hi_len = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hi_len++;
      if (sample == 4'd0) break;
    end
    lo_len = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lo_len++;
      if (sample != 4'd0) break;
    end
    chk("t1_high_level", 16'(hi_val), 16'd15);
    chk("t1_high_len", 16'(hi_len), 16'd1192);
    chk("t1_low_len", 16'(lo_len), 16'd1192);

    // Test 5: read-back masks, unmapped reads and writes
    rd_chk("rd_nr10", 16'hFF10, 1'b0, 8'h80);
    rd_chk("rd_nr11", 16'hFF11, 1'b0, 8'hBF);
    rd_chk("rd_nr12", 16'hFF12, 1'b0, 8'hF0);
    rd_chk("rd_nr13", 16'hFF13, 1'b0, 8'hFF);
    rd_chk("rd_nr14", 16'hFF14, 1'b0, 8'hBF);
    rd_chk("rd_ff15_z", 16'hFF15, 1'b1, 8'h5A);
    rd_chk("rd_fe11_z", 16'hFE11, 1'b1, 8'h5A);
    wr(16'h0F12, 8'h00);
    wr(16'hFF15, 8'h00);
    rd_chk("ign_wr_nr12", 16'hFF12, 1'b0, 8'hF0);
    @(negedge clk);
    chk("ign_wr_enabled", 16'(enabled), 16'd1);

    // Test 2: DAC off kills the channel and blocks triggers
    wr(16'hFF12, 8'h00);
    wr(16'hFF14, 8'h86);
    repeat (2) @(negedge clk);
    chk("t2_dac_off_en", 16'(enabled), 16'd0);
    chk("t2_dac_off_smp", 16'(sample), 16'd0);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF14, 8'h86);
    @(negedge clk);
    chk("t2_retrig_en", 16'(enabled), 16'd1);

    // Test 3: length 2 with length enable, then without
    wr(16'hFF11, 8'hBE);
    wr(16'hFF14, 8'hC6);
    rd_chk("rd_nr14_len", 16'hFF14, 1'b0, 8'hFF);
    wait_evt(128, 64);
    chk("t3_len_1st", 16'(enabled), 16'd1);
    wait_evt(128, 64);
    chk("t3_len_2nd", 16'(enabled), 16'd0);
    wr(16'hFF11, 8'hBE);
    wr(16'hFF14, 8'h86);
    repeat (3) wait_evt(128, 64);
    chk("t3_len_off", 16'(enabled), 16'd1);

    // DAC boundary: volume 0 with increase bit set keeps the DAC on
    wr(16'hFF12, 8'h08);
    wr(16'hFF14, 8'h86);
    repeat (2) @(negedge clk);
    chk("dac08_enabled", 16'(enabled), 16'd1);
    chk("dac08_sample", 16'(sample), 16'd0);

    // Test 6: NR10 overflow case (sweep build disables, base build ignores NR10)
    wr(16'hFF10, 8'h11);
    rd_chk("rd_nr10_w", 16'hFF10, 1'b0, 8'h91);
    wr(16'hFF11, 8'h80);
    wr(16'hFF12, 8'hF0);
    wr(16'hFF13, 8'h00);
    wr(16'hFF14, 8'h87);
    wait_evt(256, 192);
`ifdef APU_CH1_SWEEP_EN
    chk("t6_sweep_ovf", 16'(enabled), 16'd0);
`else
    chk("t6_sweep_ovf", 16'(enabled), 16'd1);
`endif
    // Negate sweep never overflows
    wr(16'hFF10, 8'h19);
    wr(16'hFF14, 8'h87);
    wait_evt(256, 192);
    chk("t6_sweep_neg", 16'(enabled), 16'd1);
    wr(16'hFF10, 8'h00);

    // Test 4: decreasing envelope, step per cycle so peak sample = volume
    wr(16'hFF11, 8'hC0);
    wr(16'hFF12, 8'hF1);
    wr(16'hFF13, 8'hFF);
    wait_evt(512, 0);
    wr(16'hFF14, 8'h87);
    peak(pk);
    chk("t4_vol_init", 16'(pk), 16'd15);
    for (int k = 1; k <= 16; k++) begin
      wait_evt(512, 0);
      if (k == 1 || k == 2 || k == 15 || k == 16) begin
        peak(pk);
        chk($sformatf("t4_vol_env%0d", k), 16'(pk), 16'((k >= 15) ? 0 : 15 - k));
      end
    end
    chk("t4_env_enabled", 16'(enabled), 16'd1);

    // Reset asserted mid-tone
    wr(16'hFF12, 8'hF0);
    wr(16'hFF14, 8'h87);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_enabled", 16'(enabled), 16'd0);
    chk("mrst_sample", 16'(sample), 16'd0);
    rd_chk("mrst_nr11", 16'hFF11, 1'b0, 8'h3F);
    rd_chk("mrst_nr12", 16'hFF12, 1'b0, 8'h00);
    rd_chk("mrst_nr14", 16'hFF14, 1'b0, 8'hBF);
    rst = 1'b0;
    @(negedge clk);
    wr(16'hFF14, 8'h80);
    repeat (2) @(negedge clk);
    chk("mrst_trig_dacoff", 16'(enabled), 16'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
